// File: rtl/subword_store_unit.sv
// subword_store_unit: narrows a 32-bit register value to byte/half/word and
// stores it into word-organised data memory behind a ready/done handshake.
// Sub-word stores use read-modify-write by default. Defining the macro
// SUBWORD_BE_EN switches them to a single byte-enabled write instead.
// Misaligned or invalid requests finish with err and never touch memory.
module subword_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        done,
  output logic        err,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  input  logic [31:0] mem_rdata,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_MRG, S_WR, S_FIN} state_t;

  state_t      state_q, state_d;
  logic [31:0] place_q, place_d;   // request data already shifted into its lanes
  logic [3:0]  lanes_q, lanes_d;   // lanes the request owns
  logic        re_q, re_d;
  logic        we_q, we_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
`ifdef SUBWORD_BE_EN
  logic [3:0]  be_q, be_d;
`endif

  logic [3:0]  req_lanes;
  logic [31:0] req_place;
  logic        req_bad;
  logic [31:0] req_place_masked;

  // Widen a 4-bit lane mask to a 32-bit bit mask.
  function automatic logic [31:0] lane_bits(input logic [3:0] l);
    return {{8{l[3]}}, {8{l[2]}}, {8{l[1]}}, {8{l[0]}}};
  endfunction

  // Decode the incoming request: owned lanes, replicated data, alignment error.
  always_comb begin
    req_lanes = 4'b0000;
    req_place = req_wdata;
    req_bad   = 1'b0;
    case (req_size)
      2'b00: begin
        req_lanes = 4'b0001 << req_addr[1:0];
        req_place = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_lanes = req_addr[1] ? 4'b1100 : 4'b0011;
        req_place = {2{req_wdata[15:0]}};
        req_bad   = req_addr[0];
      end
      2'b10: begin
        req_lanes = 4'b1111;
        req_bad   = (req_addr[1:0] != 2'b00);
      end
      default: req_bad = 1'b1;
    endcase
    req_place_masked = req_place & lane_bits(req_lanes);
  end

  // Next-state and next-output logic; strobes are decoded from the next state
  // so that they come out of flops aligned with the state they belong to.
  always_comb begin
    state_d = state_q;
    place_d = place_q;
    lanes_d = lanes_q;
    re_d    = 1'b0;
    we_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef SUBWORD_BE_EN
    be_d    = be_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          place_d = req_place_masked;
          lanes_d = req_lanes;
          if (req_bad) begin
            state_d = S_FIN;
            done_d  = 1'b1;
            err_d   = 1'b1;
`ifdef SUBWORD_BE_EN
          end else begin
            // Byte enables make every legal store a single write.
            state_d = S_WR;
            we_d    = 1'b1;
            addr_d  = {req_addr[31:2], 2'b00};
            wdata_d = req_place_masked;
            be_d    = req_lanes;
          end
`else
          end else if (req_size == 2'b10) begin
            state_d = S_WR;
            we_d    = 1'b1;
            addr_d  = {req_addr[31:2], 2'b00};
            wdata_d = req_wdata;
          end else begin
            state_d = S_RD;
            re_d    = 1'b1;
            addr_d  = {req_addr[31:2], 2'b00};
          end
`endif
        end
      end
      S_RD:  state_d = S_MRG;
      S_MRG: begin
        // Read data arrives this cycle; keep untouched lanes, replace ours.
        wdata_d = (mem_rdata & ~lane_bits(lanes_q)) | place_q;
        we_d    = 1'b1;
        state_d = S_WR;
      end
      S_WR: begin
        done_d  = 1'b1;
        state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      place_q <= 32'h0;
      lanes_q <= 4'h0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
`ifdef SUBWORD_BE_EN
      be_q    <= 4'b1111;
`endif
    end else begin
      state_q <= state_d;
      place_q <= place_d;
      lanes_q <= lanes_d;
      re_q    <= re_d;
      we_q    <= we_d;
      done_q  <= done_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef SUBWORD_BE_EN
      be_q    <= be_d;
`endif
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign mem_re    = re_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
`ifdef SUBWORD_BE_EN
  assign mem_be    = be_q;
`else
  assign mem_be    = 4'b1111;
`endif

endmodule

// File: tb/tb_subword_store_unit.sv
// Testbench for subword_store_unit: directed stores against a word memory,
// with a per-cycle expectation queue built from the store rules.
module tb_subword_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        done, err;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic [31:0] mem_rdata;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;

  subword_store_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .done(done), .err(err),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_be(mem_be)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        re, we, done, err, ready;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [0:1023];
  logic [31:0] env_mem [0:1023];
  int          total = 0;
  int          bad = 0;
  bit          chk_en = 0;
  int          we_count = 0;
  int          re_count = 0;
  logic [31:0] last_wr = 32'h0;
  int          last_idx = 0;
  logic [31:0] last_old = 32'h0;
  logic        poke_en = 1'b0;
  logic [9:0]  poke_idx = 10'h0;
  logic [31:0] poke_val = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, expv, $time);
    end
  endtask

  // Word memory seen by the DUT: one-cycle read latency, byte-enabled writes.
  always @(posedge clk) begin
    if (poke_en) env_mem[poke_idx] <= poke_val;
    if (mem_re) begin
      mem_rdata <= env_mem[mem_addr[11:2]];
      re_count  <= re_count + 1;
    end
    if (mem_we) begin
      for (int k = 0; k < 4; k++)
        if (mem_be[k]) env_mem[mem_addr[11:2]][8*k +: 8] <= mem_wdata[8*k +: 8];
      we_count <= we_count + 1;
      last_wr  <= mem_wdata;
    end
  end

  // Per-cycle compare of all DUT outputs against the expectation queue.
  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else begin
        e = '0;
        e.ready = 1'b1;
      end
      chk("req_ready", 32'(req_ready), 32'(e.ready));
      chk("mem_re", 32'(mem_re), 32'(e.re));
      chk("mem_we", 32'(mem_we), 32'(e.we));
      chk("done", 32'(done), 32'(e.done));
      chk("err", 32'(err), 32'(e.err));
      if (e.re || e.we) chk("mem_addr", mem_addr, e.addr);
      if (e.we) begin
        chk("mem_wdata", mem_wdata, e.wdata);
        chk("mem_be", 32'(mem_be), 32'(e.be));
      end
    end
  end

  // Build the cycle-by-cycle expectations of one accepted request.
  task automatic push_exp(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    exp_t        e;
    int          idx;
    logic [31:0] old_w, new_w, placed;
    logic [3:0]  lanes;
    bit          is_bad, sub;
    idx    = int'(a[11:2]);
    is_bad = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    if (is_bad) begin
      e = '0; e.done = 1'b1; e.err = 1'b1;
      exp_q.push_back(e);
      return;
    end
    old_w  = ref_mem[idx];
    new_w  = old_w;
    placed = 32'h0;
    if (sz == 2'b00) begin
      new_w[8*a[1:0] +: 8]  = wd[7:0];
      placed[8*a[1:0] +: 8] = wd[7:0];
      lanes = 4'b0001 << a[1:0];
    end else if (sz == 2'b01) begin
      new_w[16*a[1] +: 16]  = wd[15:0];
      placed[16*a[1] +: 16] = wd[15:0];
      lanes = a[1] ? 4'b1100 : 4'b0011;
    end else begin
      new_w = wd; placed = wd; lanes = 4'b1111;
    end
`ifdef SUBWORD_BE_EN
    sub = 1'b0;
`else
    sub = (sz != 2'b10);
`endif
    if (sub) begin
      e = '0; e.re = 1'b1; e.addr = {a[31:2], 2'b00};
      exp_q.push_back(e);
      e = '0;
      exp_q.push_back(e);
    end
    e = '0; e.we = 1'b1; e.addr = {a[31:2], 2'b00};
`ifdef SUBWORD_BE_EN
    e.wdata = placed; e.be = lanes;
`else
    e.wdata = new_w; e.be = 4'b1111;
`endif
    exp_q.push_back(e);
    e = '0; e.done = 1'b1;
    exp_q.push_back(e);
    last_idx = idx; last_old = old_w;
    ref_mem[idx] = new_w;
  endtask

  // Present a request at the next negedge and hold it until accepted.
  task automatic send(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    bit acc, rdy;
    @(negedge clk);
    req_valid = 1'b1; req_size = sz; req_addr = a; req_wdata = wd;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      rdy = req_ready;
      @(posedge clk);
      if (rdy) begin
        acc = 1'b1;
        push_exp(sz, a, wd);
      end else @(negedge clk);
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    $display("txn size=%0d addr=%h wdata=%h accepted=%0d t=%0t", sz, a, wd, acc, $time);
  endtask

  task automatic drain();
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic poke(input logic [31:0] a, input logic [31:0] v);
    @(negedge clk);
    poke_en = 1'b1; poke_idx = a[11:2]; poke_val = v;
    ref_mem[int'(a[11:2])] = v;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic run_lit(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] lit_rmw, input logic [31:0] lit_be);
    send(sz, a, wd);
    drain();
`ifdef SUBWORD_BE_EN
    chk("lit_wdata", last_wr, lit_be);
`else
    chk("lit_wdata", last_wr, lit_rmw);
`endif
  endtask

  task automatic run_err(input logic [1:0] sz, input logic [31:0] a);
    int n0;
    n0 = we_count + re_count;
    send(sz, a, 32'hCAFEF00D);
    drain();
    chk("err_no_strobes", 32'(we_count + re_count - n0), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_re"}, 32'(mem_re), 32'd0);
    chk({tag, "_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_addr"}, mem_addr, 32'h0);
    chk({tag, "_wdata"}, mem_wdata, 32'h0);
    chk({tag, "_be"}, 32'(mem_be), 32'hF);
  endtask

  initial begin
    int wc;
    rst_n = 1'b0; req_valid = 1'b0; req_size = 2'b00; req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
    repeat (2) @(negedge clk);
    poke(32'h100, 32'h11223344);
    poke(32'h204, 32'hAAAABBBB);
    poke(32'h300, 32'h01020304);
    chk_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Directed stores with hand-computed written words.
    run_lit(2'b00, 32'h102, 32'h123456AB, 32'h11AB3344, 32'h00AB0000);
    run_lit(2'b10, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
    run_lit(2'b01, 32'h206, 32'hFFFF8001, 32'h8001BBBB, 32'h80010000);
    run_err(2'b01, 32'h101);
    run_err(2'b10, 32'h102);
    run_err(2'b11, 32'h200);

    // Back-to-back with req_valid held high throughout.
    send(2'b00, 32'h300, 32'h000000AA);
    send(2'b00, 32'h303, 32'h00000055);
    send(2'b10, 32'h303, 32'h12345678);
    send(2'b01, 32'h300, 32'hABCD1234);
    drain();

    // Reset during the merge cycle of a byte store.
    send(2'b00, 32'h101, 32'h00000066);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk_en = 1'b0;
    exp_q.delete();
    ref_mem[last_idx] = last_old;
    wc = we_count;
    rst_n = 1'b0;
    req_valid = 1'b0;
    #1;
    chk_reset_vals("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("no_we_after_rst", 32'(we_count - wc), 32'd0);
    chk("mem_after_abort", env_mem[10'h40], 32'hDEADBEEF);
    run_lit(2'b00, 32'h101, 32'h00000077, 32'hDEAD77EF, 32'h00007700);

    // Final memory contents against the model and hand-derived values.
    chk("mem_100", env_mem[10'h40], ref_mem[10'h40]);
    chk("mem_204", env_mem[10'h81], ref_mem[10'h81]);
    chk("mem_300", env_mem[10'hC0], ref_mem[10'hC0]);
    chk("mem_300_lit", env_mem[10'hC0], 32'h55021234);
    chk("mem_204_lit", env_mem[10'h81], 32'h8001BBBB);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
